inst_cache: RTL and testbench

Direct-mapped, read-only instruction cache between the fetch stage and the block-read instruction memory. Serves hits combinationally in the same cycle and stalls fetch on a miss. On a miss it issues a block-aligned read miss to memory and fills the whole line when the memory signals ReadReady. Supports aborting an outstanding miss when the fetch is squashed, e.g. by a branch.

---
 rtl/inst_cache_if.sv | 35 +++
 rtl/inst_cache.sv | 181 ++++++++++++++++++
 tb/tb_inst_cache.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_cache_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_cache_if : fetch-side and memory-side signals of inst_cache      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface inst_cache_if #(
  parameter int BLOCK_SIZE = 4
);
  logic [31:0]              FetchAddr;
  logic                     FetchValid;
  logic                     CancelMiss;
  logic [31:0]              Instr;
  logic                     InstrValid;
  logic                     Stall;
  logic [31:0]              MemAddress;
  logic                     MemReadMiss;
  logic                     MemAbort;
  logic [32*BLOCK_SIZE-1:0] MemReadData;
  logic                     MemReadReady;
  logic [31:0]              HitCount;
  logic [31:0]              MissCount;

  modport slave (
    input  FetchAddr, FetchValid, CancelMiss, MemReadData, MemReadReady,
    output Instr, InstrValid, Stall, MemAddress, MemReadMiss, MemAbort,
           HitCount, MissCount
  );

  modport master (
    output FetchAddr, FetchValid, CancelMiss, MemReadData, MemReadReady,
    input  Instr, InstrValid, Stall, MemAddress, MemReadMiss, MemAbort,
           HitCount, MissCount
  );
endinterface
`default_nettype wire

// File: rtl/inst_cache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_cache : direct-mapped read-only instruction cache, one miss     |
// | outstanding, whole-line refill, abortable miss.        Rev 1.0       |
// +----------------------------------------------------------------------+
module inst_cache #(
  parameter int BLOCK_SIZE = 4,
  parameter int NUM_SETS   = 16
) (
  input  wire logic       Clk,
  input  wire logic       Rst,
  inst_cache_if.slave     bus
);

  localparam int c_WORD_BITS  = $clog2(BLOCK_SIZE);
  localparam int c_WSEL_W     = (c_WORD_BITS > 0) ? c_WORD_BITS : 1;
  localparam int c_INDEX_BITS = $clog2(NUM_SETS);
  localparam int c_OFF_BITS   = 2 + c_WORD_BITS;
  localparam int c_TAG_BITS   = 32 - c_OFF_BITS - c_INDEX_BITS;
  localparam int c_LINE_W     = 32 * BLOCK_SIZE;

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_MISS = 1'b1;

  logic [0:0]              r_state;
  logic [0:0]              w_next_state;

  logic [NUM_SETS-1:0]     r_valid;
  logic [c_TAG_BITS-1:0]   r_tag  [NUM_SETS];
  logic [c_LINE_W-1:0]     r_data [NUM_SETS];

  logic [31:0]             r_mem_addr;
  logic                    r_read_miss;
  logic                    r_abort;
  logic [31:0]             r_hit_cnt;
  logic [31:0]             r_miss_cnt;

  logic [c_TAG_BITS-1:0]   w_fetch_tag;
  logic [c_INDEX_BITS-1:0] w_fetch_index;
  logic [c_WSEL_W-1:0]     w_fetch_word;
  logic [c_TAG_BITS-1:0]   w_fill_tag;
  logic [c_INDEX_BITS-1:0] w_fill_index;
  logic [c_LINE_W-1:0]     w_line;
  logic [31:0]             w_word_data;
  logic                    w_hit;
  logic                    w_hit_deliver;
  logic                    w_miss_req;
  logic                    w_fill;
  logic                    w_cancel;
  logic                    w_unused;

  assign w_fetch_tag   = bus.FetchAddr[31 -: c_TAG_BITS];
  assign w_fetch_index = bus.FetchAddr[c_OFF_BITS +: c_INDEX_BITS];

  generate
    if (c_WORD_BITS > 0) begin : g_word_multi
      assign w_fetch_word = bus.FetchAddr[2 +: c_WSEL_W];
    end else begin : g_word_single
      assign w_fetch_word = '0;
    end
  endgenerate

  // Refill always targets the latched miss address, never the live FetchAddr
  assign w_fill_tag   = r_mem_addr[31 -: c_TAG_BITS];
  assign w_fill_index = r_mem_addr[c_OFF_BITS +: c_INDEX_BITS];

  assign w_line      = r_data[w_fetch_index];
  assign w_word_data = w_line[{w_fetch_word, 5'b00000} +: 32];

  assign w_hit = bus.FetchValid & r_valid[w_fetch_index]
               & (r_tag[w_fetch_index] == w_fetch_tag);

  assign w_hit_deliver = (r_state == c_IDLE) & w_hit;
  assign w_miss_req    = (r_state == c_IDLE) & bus.FetchValid & ~w_hit;
  // A fill wins over a simultaneous cancel
  assign w_fill        = (r_state == c_MISS) & bus.MemReadReady;
  assign w_cancel      = (r_state == c_MISS) & ~bus.MemReadReady & bus.CancelMiss;

  assign w_unused = ^{bus.FetchAddr[1:0], r_mem_addr[c_OFF_BITS-1:0]};

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_miss_req) begin
          w_next_state = c_MISS;
        end
      end
      c_MISS: begin
        if (bus.MemReadReady || bus.CancelMiss) begin
          w_next_state = c_IDLE;
        end
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  // Fetch-side outputs
  always_comb begin
    bus.Instr      = '0;
    bus.InstrValid = 1'b0;
    bus.Stall      = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_hit) begin
          bus.Instr      = w_word_data;
          bus.InstrValid = 1'b1;
        end else if (bus.FetchValid) begin
          bus.Stall = 1'b1;
        end
      end
      c_MISS: begin
        bus.Stall = 1'b1;
      end
      default: begin
        bus.Stall = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_valid <= '0;
    end else if (w_fill) begin
      r_valid[w_fill_index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate them
  always_ff @(posedge Clk) begin
    if (w_fill) begin
      r_tag[w_fill_index]  <= w_fill_tag;
      r_data[w_fill_index] <= bus.MemReadData;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_mem_addr  <= '0;
      r_read_miss <= 1'b0;
      r_abort     <= 1'b0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_abort <= 1'b0;
      if (w_hit_deliver) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_miss_req) begin
        r_mem_addr  <= {bus.FetchAddr[31:c_OFF_BITS], {c_OFF_BITS{1'b0}}};
        r_read_miss <= 1'b1;
        r_miss_cnt  <= r_miss_cnt + 32'd1;
      end
      if (w_fill) begin
        r_read_miss <= 1'b0;
      end
      if (w_cancel) begin
        r_read_miss <= 1'b0;
        r_abort     <= 1'b1;
      end
    end
  end

  assign bus.MemAddress  = r_mem_addr;
  assign bus.MemReadMiss = r_read_miss;
  assign bus.MemAbort    = r_abort;
  assign bus.HitCount    = r_hit_cnt;
  assign bus.MissCount   = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_inst_cache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_inst_cache : scoreboard bench for inst_cache          Rev 1.0      |
// +----------------------------------------------------------------------+
module tb_inst_cache;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  inst_cache_if #(.BLOCK_SIZE(4)) bus();

  inst_cache #(.BLOCK_SIZE(4), .NUM_SETS(16)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int total = 0;
  int bad = 0;
  int exp_hit = 0;
  int exp_miss = 0;
  int abort_seen = 0;
  logic [31:0] instr_q[$];
  logic [31:0] miss_q[$];
  logic prev_rm = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_blk(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: pops the expected instruction / miss address whenever the DUT presents one
  always @(negedge Clk) begin
    if (!Rst) begin
      if (bus.InstrValid === 1'b1) begin
        if (instr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL instr_unexpected: got %h want none", bus.Instr);
        end else begin
          chk("instr", bus.Instr, instr_q.pop_front());
        end
      end
      if (bus.MemReadMiss === 1'b1 && !prev_rm) begin
        if (miss_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL miss_unexpected: got %h want none", bus.MemAddress);
        end else begin
          chk("miss_addr", bus.MemAddress, miss_q.pop_front());
        end
      end
      if (bus.MemAbort === 1'b1) abort_seen++;
    end
    prev_rm <= bus.MemReadMiss;
  end

  task automatic start_miss(input logic [31:0] a);
    bus.FetchAddr  = a;
    bus.FetchValid = 1'b1;
    miss_q.push_back({a[31:4], 4'h0});
    #1;
    chk("miss_stall", {31'd0, bus.Stall}, 32'd1);
    step();
    exp_miss++;
    chk("readmiss_up", {31'd0, bus.MemReadMiss}, 32'd1);
    chk("miss_cnt", bus.MissCount, exp_miss);
  endtask

  task automatic fill(input logic [31:0] base, input int pre, input logic [31:0] exp_word,
                      input bit with_cancel);
    repeat (pre) step();
    bus.MemReadData  = mk_blk(base);
    bus.MemReadReady = 1'b1;
    bus.CancelMiss   = with_cancel;
    instr_q.push_back(exp_word);
    step();
    bus.MemReadReady = 1'b0;
    bus.CancelMiss   = 1'b0;
    chk("readmiss_fall", {31'd0, bus.MemReadMiss}, 32'd0);
    chk("abort_on_fill", {31'd0, bus.MemAbort}, 32'd0);
    chk("stall_after_fill", {31'd0, bus.Stall}, 32'd0);
    step();
    exp_hit++;
    chk("hit_cnt", bus.HitCount, exp_hit);
    bus.FetchValid = 1'b0;
  endtask

  task automatic hit(input logic [31:0] a, input logic [31:0] w);
    bus.FetchAddr  = a;
    bus.FetchValid = 1'b1;
    instr_q.push_back(w);
    #1;
    chk("hit_stall", {31'd0, bus.Stall}, 32'd0);
    step();
    exp_hit++;
    chk("hit_cnt", bus.HitCount, exp_hit);
    bus.FetchValid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.FetchAddr    = '0;
    bus.FetchValid   = 1'b0;
    bus.CancelMiss   = 1'b0;
    bus.MemReadData  = '0;
    bus.MemReadReady = 1'b0;
    repeat (3) step();
    Rst = 1'b0;
    #1;
    chk("rst_readmiss", {31'd0, bus.MemReadMiss}, 32'd0);
    chk("rst_abort", {31'd0, bus.MemAbort}, 32'd0);
    chk("rst_memaddr", bus.MemAddress, 32'd0);
    chk("rst_hitcnt", bus.HitCount, 32'd0);
    chk("rst_misscnt", bus.MissCount, 32'd0);
    chk("idle_stall", {31'd0, bus.Stall}, 32'd0);
    chk("idle_instr", bus.Instr, 32'd0);

    // Cold miss, 20-cycle refill, then a second word from the same line
    start_miss(32'h44);
    fill(32'hA0, 19, 32'hA1, 1'b0);
    hit(32'h4C, 32'hA3);
    chk("no_new_miss", {31'd0, bus.MemReadMiss}, 32'd0);
    chk("t1_misscnt", bus.MissCount, 32'd1);

    // Conflict eviction in index 4
    start_miss(32'h140);
    fill(32'hB0, 5, 32'hB0, 1'b0);
    start_miss(32'h40);
    fill(32'hA0, 3, 32'hA0, 1'b0);

    // Abort five cycles into a miss; fetch is squashed at the same time
    start_miss(32'h200);
    repeat (4) step();
    bus.CancelMiss = 1'b1;
    bus.FetchValid = 1'b0;
    step();
    bus.CancelMiss = 1'b0;
    chk("abort_pulse", {31'd0, bus.MemAbort}, 32'd1);
    chk("abort_readmiss", {31'd0, bus.MemReadMiss}, 32'd0);
    chk("abort_stall", {31'd0, bus.Stall}, 32'd0);
    step();
    chk("abort_drop", {31'd0, bus.MemAbort}, 32'd0);

    // Refetch misses again; cancel and ready together fill the line
    start_miss(32'h200);
    fill(32'hC0, 2, 32'hC0, 1'b1);
    hit(32'h208, 32'hC2);

    // Asynchronous reset mid-miss
    start_miss(32'h300);
    repeat (9) step();
    #2;
    Rst = 1'b1;
    bus.FetchValid = 1'b0;
    #1;
    chk("amid_readmiss", {31'd0, bus.MemReadMiss}, 32'd0);
    chk("amid_hitcnt", bus.HitCount, 32'd0);
    chk("amid_misscnt", bus.MissCount, 32'd0);
    exp_hit  = 0;
    exp_miss = 0;
    step();
    Rst = 1'b0;
    start_miss(32'h40);
    fill(32'hA0, 3, 32'hA0, 1'b0);

    // FetchAddr changes while in MISS are ignored
    start_miss(32'h80);
    step();
    bus.FetchAddr = 32'h300;
    step();
    step();
    chk("hold_addr", bus.MemAddress, 32'h80);
    chk("hold_stall", {31'd0, bus.Stall}, 32'd1);
    bus.MemReadData  = mk_blk(32'hD0);
    bus.MemReadReady = 1'b1;
    miss_q.push_back(32'h300);
    step();
    bus.MemReadReady = 1'b0;
    chk("relookup_stall", {31'd0, bus.Stall}, 32'd1);
    step();
    exp_miss++;
    chk("relookup_readmiss", {31'd0, bus.MemReadMiss}, 32'd1);
    chk("relookup_addr", bus.MemAddress, 32'h300);
    chk("relookup_misscnt", bus.MissCount, exp_miss);
    fill(32'hE0, 2, 32'hE0, 1'b0);
    hit(32'h84, 32'hD1);

    step();
    chk("instr_q_empty", instr_q.size(), 32'd0);
    chk("miss_q_empty", miss_q.size(), 32'd0);
    chk("abort_pulses", abort_seen, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
